// File: rtl/mac_fxp_pkg.sv
// Shared fixed-point constants for the MAC datapath: default formats,
// requantization shift and output saturation limits.
package mac_fxp_pkg;

   localparam int DEF_ACCUM_WIDTH = 32;  // S15.16
   localparam int DEF_ACCUM_FRAC  = 16;
   localparam int DEF_OUT_WIDTH   = 16;  // S5.10
   localparam int DEF_OUT_FRAC    = 10;

   localparam int SHIFT   = DEF_ACCUM_FRAC - DEF_OUT_FRAC;
   localparam int SAT_MAX = (1 << (DEF_OUT_WIDTH - 1)) - 1;
   localparam int SAT_MIN = -(1 << (DEF_OUT_WIDTH - 1));

   // Largest positive value of a signed field `width` bits wide.
   function automatic longint sat_hi(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

endpackage

// File: rtl/qout_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is only
// accepted when a pop happens in the same cycle; otherwise it is ignored.
module qout_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   // Storage carries no reset; validity lives entirely in the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/accum_requant.sv
// Collects MAC beats, adds bias on the final beat, then applies ReLU,
// round-half-up requantization and saturation before queueing the result.
module accum_requant import mac_fxp_pkg::*; #(
   parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
   parameter int ACCUM_FRAC  = DEF_ACCUM_FRAC,
   parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
   parameter int OUT_FRAC    = DEF_OUT_FRAC,
   parameter int VEC_LEN     = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ACCUM_WIDTH-1:0] accum_in,
   input  logic                   accum_valid,
   input  logic [ACCUM_WIDTH-1:0] bias_in,
   input  logic                   relu_en,
   input  logic                   flush,
   output logic [OUT_WIDTH-1:0]   out_data,
   output logic                   out_sat,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   drop_err
);

   localparam int AW    = ACCUM_WIDTH;
   localparam int SH    = ACCUM_FRAC - OUT_FRAC;
   localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [CNT_W-1:0]    LAST   = CNT_W'(VEC_LEN - 1);
   localparam logic signed [AW+1:0] RND    = (AW+2)'(1) <<< (SH - 1);
   localparam logic signed [AW+1:0] SAT_HI = (AW+2)'(sat_hi(OUT_WIDTH));
   localparam logic signed [AW+1:0] SAT_LO = ~SAT_HI;

   logic [CNT_W-1:0]       beat_cnt;
   logic                   final_beat;
   logic                   s1_valid;
   logic signed [AW:0]     s1_sum;
   logic                   s1_relu;
   logic                   s2_valid;
   logic [OUT_WIDTH-1:0]   s2_data;
   logic                   s2_sat;
   logic signed [AW:0]     relu_v;
   logic signed [AW+1:0]   rnd_v;
   logic signed [AW+1:0]   shf_v;
   logic [OUT_WIDTH-1:0]   q_data;
   logic                   q_sat;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic [OUT_WIDTH:0]     fifo_rdata;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   assign final_beat = accum_valid && !flush && (beat_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || flush)     beat_cnt <= '0;
      else if (accum_valid) beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= final_beat;
         s2_valid <= s1_valid;
      end
   end

   // One extra bit so accumulator plus bias can never wrap.
   always_ff @(posedge clk) begin
      if (final_beat) begin
         s1_sum  <= $signed({accum_in[AW-1], accum_in}) + $signed({bias_in[AW-1], bias_in});
         s1_relu <= relu_en;
      end
   end

   always_comb begin
      relu_v = (s1_relu && s1_sum[AW]) ? '0 : s1_sum;
      rnd_v  = $signed({relu_v[AW], relu_v}) + RND;
      shf_v  = rnd_v >>> SH;
      q_sat  = 1'b0;
      q_data = shf_v[OUT_WIDTH-1:0];
      if (shf_v > SAT_HI) begin
         q_sat  = 1'b1;
         q_data = SAT_HI[OUT_WIDTH-1:0];
      end else if (shf_v < SAT_LO) begin
         q_sat  = 1'b1;
         q_data = SAT_LO[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (s1_valid) begin
         s2_data <= q_data;
         s2_sat  <= q_sat;
      end
   end

   assign fifo_push = s2_valid && !flush;
   assign fifo_pop  = out_ready && (fifo_count != '0);

   // A full FIFO only loses the result when nothing leaves the same cycle.
   always_ff @(posedge clk) begin
      if (rst)                                       drop_err <= 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop)  drop_err <= 1'b1;
   end

   qout_fifo #(
      .WIDTH (OUT_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (fifo_push),
      .wdata ({s2_sat, s2_data}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_empty ? '0 : fifo_rdata[OUT_WIDTH-1:0];
   assign out_sat   = !fifo_empty && fifo_rdata[OUT_WIDTH];

endmodule
